// File: rtl/deck_shuffler_pkg.sv
// card_pkg: shared constants, FSM state type and card decode helpers for the
// deck shuffler.
//   DECK_SIZE / RANKS / IDX_W : deck geometry
//   state_t                   : shuffler FSM states
//   card_info_t               : decoded {value, face, ace} for one card
//   decode_card()             : card index -> blackjack value and flags
//   draw_mask()               : smallest 2^n-1 covering a swap position
//   reduce_addr()             : folds addresses 52..63 back onto the deck
package card_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;
  localparam int IDX_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_READY,
    ST_FETCH
  } state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       face;
    logic       ace;
  } card_info_t;

  // Suit is irrelevant to blackjack, so only the rank (index mod 13) matters.
  function automatic card_info_t decode_card(input logic [IDX_W-1:0] idx);
    card_info_t info;
    logic [IDX_W-1:0] rank;
    rank      = idx % 6'(RANKS);
    info.ace  = (rank == 6'd0);
    info.face = (rank >= 6'd10);
    if (rank == 6'd0)
      info.value = 4'd1;
    else if (rank >= 6'd10)
      info.value = 4'd10;
    else
      info.value = rank[3:0] + 4'd1;
    return info;
  endfunction

  // Masking the LFSR to the smallest all-ones value >= i keeps the rejection
  // rate below one half while staying uniform over 0..i.
  function automatic logic [IDX_W-1:0] draw_mask(input logic [IDX_W-1:0] i);
    if (i <= 6'd1)
      return 6'd1;
    else if (i <= 6'd3)
      return 6'd3;
    else if (i <= 6'd7)
      return 6'd7;
    else if (i <= 6'd15)
      return 6'd15;
    else if (i <= 6'd31)
      return 6'd31;
    else
      return 6'd63;
  endfunction

  function automatic logic [IDX_W-1:0] reduce_addr(input logic [IDX_W-1:0] addr);
    if (addr >= 6'(DECK_SIZE))
      return addr - 6'(DECK_SIZE);
    else
      return addr;
  endfunction

endpackage

// File: rtl/deck_shuffler_if.sv
// deck_shuffler_if: card-request bus between the Blackjack controller
// (master) and the deck shuffler (slave).
//   Shuffler        : shuffle request level (master -> slave)
//   Sum             : card request level (master -> slave)
//   i_Memory_Adress : deck position to read (master -> slave)
//   Finish          : deck shuffled and readable (slave -> master)
//   Ok              : one-cycle strobe, card fields valid (slave -> master)
//   Card_Value      : blackjack value 1..10 (slave -> master)
//   o_Face / o_Ace  : card is J/Q/K / card is an ace (slave -> master)
interface deck_shuffler_if;
  import card_pkg::*;

  logic             Shuffler;
  logic             Sum;
  logic [IDX_W-1:0] i_Memory_Adress;
  logic             Finish;
  logic             Ok;
  logic [3:0]       Card_Value;
  logic             o_Face;
  logic             o_Ace;

  modport master (
    output Shuffler, Sum, i_Memory_Adress,
    input  Finish, Ok, Card_Value, o_Face, o_Ace
  );

  modport slave (
    input  Shuffler, Sum, i_Memory_Adress,
    output Finish, Ok, Card_Value, o_Face, o_Ace
  );

endinterface

// File: rtl/deck_shuffler_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, polynomial 0xB400.
//   Clock      : rising-edge clock
//   Reset      : asynchronous active-high reset, loads the seed
//   lfsr_state : current 16-bit register contents
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] lfsr_state
);

  // An all-zero seed would lock the register up, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] POLY     = 16'hB400;

  // Advances every cycle regardless of what the rest of the design is doing.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      lfsr_state <= SEED_EFF;
    else if (lfsr_state[0])
      lfsr_state <= (lfsr_state >> 1) ^ POLY;
    else
      lfsr_state <= lfsr_state >> 1;
  end

endmodule

// File: rtl/deck_shuffler.sv
// deck_shuffler: 52-card deck store with Fisher-Yates shuffle for the
// Blackjack table.
//   SEED       : LFSR reset value (0 is replaced by 1)
//   SHUFFLE_EN : 0 leaves the deck in identity order after initialisation
//   Clock      : rising-edge clock
//   Reset      : asynchronous active-high reset
//   bus        : deck_shuffler_if slave port (requests in, card data out)
module deck_shuffler
  import card_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter bit          SHUFFLE_EN = 1'b1
) (
  input  logic            Clock,
  input  logic            Reset,
  deck_shuffler_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] deck [DECK_SIZE];
  logic [IDX_W-1:0] init_idx;
  logic [IDX_W-1:0] swap_idx;
  logic [IDX_W-1:0] draw;
  logic             draw_ok;
  logic [15:0]      lfsr_state;
  logic             lfsr_unused;
  logic             shuf_prev;
  logic             sum_prev;
  logic             shuf_edge;
  logic             sum_edge;
  logic             init_we;
  logic             swap_we;
  logic             fetch_load;
  card_info_t       card_q;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .Clock      (Clock),
    .Reset      (Reset),
    .lfsr_state (lfsr_state)
  );

  // Only the low six bits pick swap partners; the rest just carry the sequence.
  assign lfsr_unused = ^lfsr_state[15:IDX_W];
  assign draw        = lfsr_state[IDX_W-1:0] & draw_mask(swap_idx);
  assign draw_ok     = (draw <= swap_idx);

  // Registered edge detectors: a rising input shows up as a one-cycle pulse
  // in the following cycle, so a held level yields exactly one request.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shuf_prev <= 1'b0;
      sum_prev  <= 1'b0;
      shuf_edge <= 1'b0;
      sum_edge  <= 1'b0;
    end else begin
      shuf_prev <= bus.Shuffler;
      sum_prev  <= bus.Sum;
      shuf_edge <= bus.Shuffler & ~shuf_prev;
      sum_edge  <= bus.Sum & ~sum_prev;
    end
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state and control decode. A shuffle request in READY beats a card
  // request arriving in the same cycle; requests in other states are dropped.
  always_comb begin
    state_next = state;
    init_we    = 1'b0;
    swap_we    = 1'b0;
    fetch_load = 1'b0;
    bus.Finish = 1'b0;
    bus.Ok     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (shuf_edge)
          state_next = ST_INIT;
      end
      ST_INIT: begin
        init_we = 1'b1;
        if (init_idx == 6'(DECK_SIZE - 1))
          state_next = SHUFFLE_EN ? ST_SHUFFLE : ST_READY;
      end
      ST_SHUFFLE: begin
        swap_we = draw_ok;
        if (draw_ok && (swap_idx == 6'd1))
          state_next = ST_READY;
      end
      ST_READY: begin
        bus.Finish = 1'b1;
        if (shuf_edge) begin
          state_next = ST_INIT;
        end else if (sum_edge) begin
          fetch_load = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        bus.Ok     = 1'b1;
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Walking indices: init_idx counts up through INIT, swap_idx counts down
  // through SHUFFLE and only moves on an accepted draw.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      init_idx <= '0;
      swap_idx <= 6'(DECK_SIZE - 1);
    end else begin
      if (state == ST_INIT)
        init_idx <= init_idx + 6'd1;
      else
        init_idx <= '0;
      if (state != ST_SHUFFLE)
        swap_idx <= 6'(DECK_SIZE - 1);
      else if (draw_ok)
        swap_idx <= swap_idx - 6'd1;
    end
  end

  // Deck storage has no reset; its contents only matter after INIT rewrites
  // every entry. A swap with r == i writes the same value twice, harmlessly.
  always_ff @(posedge Clock) begin
    if (init_we) begin
      deck[init_idx] <= init_idx;
    end else if (swap_we) begin
      deck[swap_idx] <= deck[draw];
      deck[draw]     <= deck[swap_idx];
    end
  end

  // The array is read and decoded on the edge that accepts the request, so
  // the card is already registered when FETCH raises Ok. The fields then hold
  // until the next accepted request.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      card_q <= '0;
    else if (fetch_load)
      card_q <= decode_card(deck[reduce_addr(bus.i_Memory_Adress)]);
  end

  assign bus.Card_Value = card_q.value;
  assign bus.o_Face     = card_q.face;
  assign bus.o_Ace      = card_q.ace;

endmodule

// File: tb/tb_deck_shuffler.sv
// tb_deck_shuffler: self-checking bench for deck_shuffler. One instance
// shuffles, a second runs with shuffling disabled to expose identity order.
// Expected decks come from a Fisher-Yates model driven by a bench-side LFSR
// sequence indexed by the number of clock cycles since reset.
module tb_deck_shuffler;

  localparam logic [15:0] SEED = 16'hACE1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  int checks = 0;
  int errors = 0;
  int lfsr_steps;
  int model_deck [52];
  int model_draws;
  logic [311:0] sigs [10];

  deck_shuffler_if bus_shuf ();
  deck_shuffler_if bus_ident ();

  deck_shuffler #(.SEED(SEED), .SHUFFLE_EN(1'b1)) dut_shuf (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_shuf)
  );

  deck_shuffler #(.SEED(SEED), .SHUFFLE_EN(1'b0)) dut_ident (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_ident)
  );

  always #5 Clock = ~Clock;

  // Number of LFSR advances since reset: one per rising edge out of reset.
  always @(posedge Clock or posedge Reset) begin
    if (Reset)
      lfsr_steps <= 0;
    else
      lfsr_steps <= lfsr_steps + 1;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr_at(input int steps);
    logic [15:0] v;
    v = SEED;
    for (int k = 0; k < steps; k++)
      v = lfsr_next(v);
    return v;
  endfunction

  function automatic int exp_value(input int idx);
    int rank;
    rank = idx % 13;
    if (rank == 0) return 1;
    if (rank >= 10) return 10;
    return rank + 1;
  endfunction

  function automatic int exp_face(input int idx);
    return ((idx % 13) >= 10) ? 1 : 0;
  endfunction

  function automatic int exp_ace(input int idx);
    return ((idx % 13) == 0) ? 1 : 0;
  endfunction

  // Fisher-Yates on an int array: one draw per cycle, starting from the LFSR
  // value present during the first shuffle cycle.
  task automatic model_shuffle(input int start_steps);
    logic [15:0] v;
    int i, m, r, t;
    v = lfsr_at(start_steps);
    for (int k = 0; k < 52; k++)
      model_deck[k] = k;
    model_draws = 0;
    i = 51;
    while (i >= 1) begin
      m = 1;
      while (m < i)
        m = m * 2 + 1;
      r = int'(v[5:0]) & m;
      model_draws++;
      if (r <= i) begin
        t             = model_deck[i];
        model_deck[i] = model_deck[r];
        model_deck[r] = t;
        i--;
      end
      v = lfsr_next(v);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit on_shuf, input bit shuf, input bit sum, input int addr);
    if (on_shuf) begin
      bus_shuf.Shuffler        = shuf;
      bus_shuf.Sum             = sum;
      bus_shuf.i_Memory_Adress = 6'(addr);
    end else begin
      bus_ident.Shuffler        = shuf;
      bus_ident.Sum             = sum;
      bus_ident.i_Memory_Adress = 6'(addr);
    end
  endtask

  task automatic read_card(input bit on_shuf, input int addr, input int exp_idx,
                           input string tag, output logic [5:0] seen);
    logic [3:0] v;
    logic f, a, ok;
    applyStimulus(on_shuf, 1'b0, 1'b1, addr);
    tick;
    ok = on_shuf ? bus_shuf.Ok : bus_ident.Ok;
    checkOutput({tag, " ok_early"}, ok, 0);
    tick;
    ok = on_shuf ? bus_shuf.Ok : bus_ident.Ok;
    v  = on_shuf ? bus_shuf.Card_Value : bus_ident.Card_Value;
    f  = on_shuf ? bus_shuf.o_Face : bus_ident.o_Face;
    a  = on_shuf ? bus_shuf.o_Ace : bus_ident.o_Ace;
    checkOutput({tag, " ok"}, ok, 1);
    checkOutput({tag, " value"}, v, exp_value(exp_idx));
    checkOutput({tag, " face"}, f, exp_face(exp_idx));
    checkOutput({tag, " ace"}, a, exp_ace(exp_idx));
    seen = {a, f, v};
    applyStimulus(on_shuf, 1'b0, 1'b0, addr);
    tick;
    ok = on_shuf ? bus_shuf.Ok : bus_ident.Ok;
    v  = on_shuf ? bus_shuf.Card_Value : bus_ident.Card_Value;
    checkOutput({tag, " ok_end"}, ok, 0);
    checkOutput({tag, " hold"}, v, exp_value(exp_idx));
  endtask

  // Requests a shuffle after a gap, pokes Sum mid-shuffle, and checks Finish
  // arrives exactly after INIT plus the model's draw count.
  task automatic run_shuffle(input int gap, input bit with_sum, input string tag);
    int cyc;
    bit done;
    repeat (gap) tick;
    model_shuffle(lfsr_steps + 54);
    applyStimulus(1'b1, 1'b1, with_sum, 0);
    cyc  = 0;
    done = 0;
    while (!done && cyc < 3000) begin
      tick;
      cyc++;
      if (cyc == 2) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkOutput({tag, " finish_drop"}, bus_shuf.Finish, 0);
      end
      if (cyc == 60) applyStimulus(1'b1, 1'b0, 1'b1, 0);
      if (cyc == 62) applyStimulus(1'b1, 1'b0, 1'b0, 0);
      checkOutput({tag, " ok_quiet"}, bus_shuf.Ok, 0);
      if (cyc >= 3 && bus_shuf.Finish) done = 1;
    end
    checkOutput({tag, " finish_latency"}, cyc, 54 + model_draws);
  endtask

  task automatic read_all(input string tag, output logic [311:0] sig);
    logic [5:0] seen;
    int hist [11];
    int faces, aces;
    faces = 0;
    aces  = 0;
    sig   = '0;
    for (int v = 0; v < 11; v++) hist[v] = 0;
    for (int k = 0; k < 52; k++) begin
      read_card(1'b1, k, model_deck[k], $sformatf("%s addr%0d", tag, k), seen);
      sig[k*6 +: 6] = seen;
      if (seen[3:0] <= 4'd10) hist[seen[3:0]]++;
      if (seen[4] === 1'b1) faces++;
      if (seen[5] === 1'b1) aces++;
    end
    for (int v = 1; v <= 10; v++)
      checkOutput($sformatf("%s hist_value%0d", tag, v), hist[v], (v == 10) ? 16 : 4);
    checkOutput({tag, " face_count"}, faces, 12);
    checkOutput({tag, " ace_count"}, aces, 4);
  endtask

  initial begin
    int cyc;
    int addr;
    int ident_addrs [7];
    logic [5:0] seen;
    logic [311:0] sig;

    ident_addrs = '{0, 9, 11, 13, 52, 63, 51};
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset finish", bus_shuf.Finish, 0);
    checkOutput("reset ok", bus_shuf.Ok, 0);
    checkOutput("reset value", bus_shuf.Card_Value, 0);
    checkOutput("reset face", bus_shuf.o_Face, 0);
    checkOutput("reset ace", bus_shuf.o_Ace, 0);
    checkOutput("reset ident finish", bus_ident.Finish, 0);
    Reset = 1'b0;
    tick;

    $display("[TB] identity deck");
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    cyc = 0;
    while (cyc < 200) begin
      tick;
      cyc++;
      if (cyc == 2) applyStimulus(1'b0, 1'b0, 1'b0, 0);
      if (bus_ident.Finish) break;
    end
    checkOutput("ident finish_latency", cyc, 54);
    foreach (ident_addrs[j]) begin
      addr = ident_addrs[j];
      read_card(1'b0, addr, (addr >= 52) ? addr - 52 : addr,
                $sformatf("ident addr%0d", addr), seen);
    end

    $display("[TB] back-to-back shuffles");
    for (int s = 0; s < 10; s++) begin
      run_shuffle($urandom_range(0, 9), (s == 4), $sformatf("shuffle%0d", s));
      read_all($sformatf("deck%0d", s), sig);
      sigs[s] = sig;
      for (int p = 0; p < s; p++)
        checkOutput($sformatf("deck%0d vs deck%0d distinct", s, p), (sigs[s] !== sigs[p]) ? 1 : 0, 1);
      if (s == 0) begin
        for (int j = 0; j < 6; j++) begin
          addr = $urandom_range(0, 63);
          read_card(1'b1, addr, model_deck[(addr >= 52) ? addr - 52 : addr],
                    $sformatf("random addr%0d", addr), seen);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 5);
        for (int k = 1; k <= 5; k++) begin
          tick;
          checkOutput($sformatf("held_sum ok c%0d", k), bus_shuf.Ok, (k == 2) ? 1 : 0);
        end
        checkOutput("held_sum value", bus_shuf.Card_Value, exp_value(model_deck[5]));
        applyStimulus(1'b1, 1'b0, 1'b0, 5);
        tick;
      end
    end

    $display("[TB] reset during shuffle");
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    for (int k = 1; k <= 70; k++) begin
      tick;
      if (k == 2) applyStimulus(1'b1, 1'b0, 1'b0, 0);
    end
    Reset = 1'b1;
    #1;
    checkOutput("midreset finish", bus_shuf.Finish, 0);
    checkOutput("midreset ok", bus_shuf.Ok, 0);
    checkOutput("midreset value", bus_shuf.Card_Value, 0);
    checkOutput("midreset face", bus_shuf.o_Face, 0);
    checkOutput("midreset ace", bus_shuf.o_Ace, 0);
    tick;
    tick;
    Reset = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick;
      checkOutput("postreset finish", bus_shuf.Finish, 0);
      checkOutput("postreset ok", bus_shuf.Ok, 0);
    end
    run_shuffle(3, 1'b0, "after_reset");
    read_all("after_reset deck", sig);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deck_shuffler.md
# deck_shuffler

Card-deck store and shuffler for the Blackjack table. It sits directly upstream of the Blackjack controller. On `Shuffler` it builds a 52-card deck and permutes it with a Fisher–Yates pass driven by an LFSR, then raises `Finish`. It serves each card request (`Sum` plus `o_Memory_Adress` from the controller) by returning the card's blackjack value and face/ace flags with an `Ok` strobe.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `SHUFFLE_EN`, default 1: when 0, the deck stays in identity order after INIT (test mode).
- `Clock`  in  1  single system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Shuffler`  in  1  shuffle request (level; acted on at its rising edge).
- `Sum`  in  1  card request (acted on at its rising edge).
- `i_Memory_Adress`  in  6  deck position to read, driven by the controller's `o_Memory_Adress`.
- `Finish`  out  1  deck shuffled and readable (level).
- `Ok`  out  1  one-cycle strobe: card outputs are valid.
- `Card_Value`  out  4  blackjack value 1..10; an ace reports 1.
- `o_Face`  out  1  card is J, Q or K.
- `o_Ace`  out  1  card is an ace.

## Operation
- Deck storage: 52×6-bit register array holding card indices 0..51.
  - rank = index mod 13; suit is ignored.
  - rank 0 = ace: value 1, `o_Ace`=1.
  - ranks 1..9: value rank+1.
  - ranks 10..12: value 10, `o_Face`=1.
- LFSR: 16-bit Galois, polynomial 0xB400. It advances every cycle in every state, so player timing adds entropy.
- FSM states:
  - IDLE: waits for a `Shuffler` rising edge, then goes to INIT.
  - INIT: writes deck[k]=k for k=0..51, one entry per cycle (52 cycles). Goes to SHUFFLE, or to READY if SHUFFLE_EN=0.
  - SHUFFLE: i runs from 51 down to 1.
    - Each cycle, candidate r = lfsr[5:0] & mask(i), where mask(i) is the smallest 2^n−1 ≥ i.
    - If r ≤ i: swap deck[i] and deck[r] in the same cycle, then decrement i.
    - Else reject and redraw next cycle.
    - After the i=1 swap, go to READY.
  - READY: `Finish`=1.
    - A `Sum` rising edge latches the address and goes to FETCH.
    - A `Shuffler` rising edge goes to INIT and clears `Finish`.
  - FETCH: registers the decoded card, pulses `Ok`, returns to READY.
- Address rule: an address ≥52 is reduced to address−52 (63 maps to 11).
- `Sum` edges outside READY are ignored, not queued.
- `Shuffler` edges in INIT, SHUFFLE or FETCH are ignored.
- If `Sum` and `Shuffler` rise in the same READY cycle, the shuffle wins and no `Ok` is produced.

## Timing
- Reset values: FSM in IDLE, `Finish`=0, `Ok`=0, `Card_Value`=0, `o_Face`=0, `o_Ace`=0, LFSR=SEED. Deck contents are don't-care until INIT completes.
- Reset asserted mid-shuffle or mid-fetch: all outputs take their reset values asynchronously and no `Ok` is emitted afterwards.
- Edge detection: `Shuffler` and `Sum` are registered once; a rising edge is seen one cycle after the input rises.
- Shuffle latency: INIT 52 cycles + 51 accepted draws + rejected draws. `Finish` rises the cycle after the last swap.
- Fetch latency:
  - `Sum` rises at cycle n; the edge is detected at n+1.
  - The array is read at n+1; `Ok`=1 with valid data at n+2.
  - `Card_Value`, `o_Face` and `o_Ace` hold their values until the next fetch.
- `Sum` held high produces exactly one `Ok`.

## Structure
- Package `card_pkg`:
  - `DECK_SIZE`=52, `RANKS`=13.
  - FSM state typedef.
  - Rank-to-{value, face, ace} decode function.
- Sub-module `lfsr16`: parameterised seed, free-running, exposes the 16-bit state.

## Test plan
- Reset → all outputs 0, `Finish`=0. Pulse `Reset` mid-SHUFFLE → `Finish` stays 0 and a later `Shuffler` completes normally.
- SHUFFLE_EN=0: `Shuffler` → `Finish` high after 52 cycles (plus edge-detect delay). Then read:
  - addr 0 → value 1, `o_Ace`=1.
  - addr 9 → value 10, `o_Face`=0.
  - addr 11 → value 10, `o_Face`=1.
  - addr 13 → `o_Ace`=1.
  - addr 52 → same as addr 0.
- SHUFFLE_EN=1, SEED 16'hACE1: after `Finish`, read all 52 addresses → every index 0..51 appears exactly once, and order matches the golden model.
- `Sum` held high 5 cycles in READY → exactly one `Ok`, at cycle n+2. `Sum` pulses during SHUFFLE → no `Ok`.
- `Sum` and `Shuffler` rising in the same READY cycle → no `Ok`, `Finish` drops, and a new permutation completes.
- Ten back-to-back shuffles with different inter-request delays → all permutations valid, none identical.
